// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// The SERIAL_ADDER_SUB_EN macro enables the subtract mode.
package serial_adder_pkg;

   localparam int MIN_WIDTH = 2;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   function automatic int cnt_width(int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, overflow
   );
`else
   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder shared by every serial step.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN for a - b via the sub request bit.
import serial_adder_pkg::*;

module serial_adder #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             c_msb;
   logic             fa_s;
   logic             fa_co;
   logic             accept;
   logic             last;
   logic             pre_msb;
   logic [WIDTH-1:0] b_op;
   logic             c_op;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_op = bus.sub ? ~bus.b : bus.b;
   assign c_op = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_op = bus.b;
   assign c_op = bus.cin;
`endif

   assign accept  = (state == IDLE) && bus.start;
   assign last    = (state == RUN) && (count == CNT_W'(WIDTH - 1));
   assign pre_msb = (count == CNT_W'(WIDTH - 2));
   assign bus.busy = (state == RUN);

   fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.start) state_nx = RUN;
         RUN:  if (last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         a_sh         <= '0;
         b_sh         <= '0;
         s_sh         <= '0;
         count        <= '0;
         carry        <= 1'b0;
         c_msb        <= 1'b0;
         bus.done     <= 1'b0;
         bus.sum      <= '0;
         bus.cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         state    <= state_nx;
         bus.done <= 1'b0;
         if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= b_op;
            carry <= c_op;
            count <= '0;
         end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
            carry <= fa_co;
            count <= count + CNT_W'(1);
            // carry produced here feeds the MSB step
            if (pre_msb) c_msb <= fa_co;
            if (last) begin
               bus.sum      <= {fa_s, s_sh[WIDTH-1:1]};
               bus.cout     <= fa_co;
               bus.overflow <= c_msb ^ fa_co;
               bus.done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic c, output int lat,
                         output int busy_n);
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.cin = c;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      busy_n = 0;
      for (int i = 1; i <= 20; i++) begin
         if (bus.busy === 1'b1) busy_n++;
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000",
                  {bus.busy, bus.done, bus.cout, bus.overflow});
      end
      n_chk++;
      if (bus.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_sum: got %h want 00", bus.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add(input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [7:0] es,
                           input logic ec, input logic ev);
      int lat;
      int bn;
      run_op(a, b, c, lat, bn);
      n_chk++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL add_latency %h+%h: got %0d want 8", a, b, lat);
      end
      n_chk++;
      if (bn !== 8) begin
         n_fail++;
         $display("FAIL add_busy %h+%h: got %0d want 8", a, b, bn);
      end
      n_chk++;
      if ({bus.sum, bus.cout, bus.overflow} !== {es, ec, ev}) begin
         n_fail++;
         $display("FAIL add_result %h+%h+%b: got %h c%b v%b want %h c%b v%b",
                  a, b, c, bus.sum, bus.cout, bus.overflow, es, ec, ev);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_width %h+%h: got %b want 0", a, b, bus.done);
      end
   endtask

   task automatic test_ignore_start;
      int dones;
      int at;
      logic [7:0] dsum;
      @(negedge clk);
      bus.a = 8'h01;
      bus.b = 8'h01;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      dones = 0;
      at = -1;
      dsum = 8'hxx;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin
            bus.a = 8'hF0;
            bus.start = 1'b1;
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (i == 5) begin
            n_chk++;
            if (bus.sum !== 8'h80) begin
               n_fail++;
               $display("FAIL sum_hold: got %h want 80", bus.sum);
            end
         end
         if (bus.done === 1'b1) begin
            dones++;
            if (at < 0) at = i;
            dsum = bus.sum;
         end
      end
      n_chk++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL ignore_dones: got %0d want 1", dones);
      end
      n_chk++;
      if (at !== 8) begin
         n_fail++;
         $display("FAIL ignore_latency: got %0d want 8", at);
      end
      n_chk++;
      if (dsum !== 8'h02) begin
         n_fail++;
         $display("FAIL ignore_sum: got %h want 02", dsum);
      end
   endtask

   task automatic test_reset_mid;
      int dones;
      @(negedge clk);
      bus.a = 8'h55;
      bus.b = 8'h11;
      bus.cin = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0) begin
         n_fail++;
         $display("FAIL midreset_flags: got %b want 0000",
                  {bus.busy, bus.done, bus.cout, bus.overflow});
      end
      n_chk++;
      if (bus.sum !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_sum: got %h want 00", bus.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      n_chk++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL midreset_quiet: got %0d want 0", dones);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      int bn;
      int gap;
      run_op(8'h10, 8'h20, 1'b0, lat, bn);
      n_chk++;
      if (lat !== 8 || bus.sum !== 8'h30) begin
         n_fail++;
         $display("FAIL b2b_first: got lat %0d sum %h want 8 30",
                  lat, bus.sum);
      end
      bus.a = 8'h03;
      bus.b = 8'h04;
      bus.start = 1'b1;
      gap = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            gap = i;
            break;
         end
      end
      n_chk++;
      if (gap !== 9) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d want 9", gap);
      end
      n_chk++;
      if ({bus.sum, bus.cout, bus.overflow} !== {8'h07, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_second: got %h c%b v%b want 07 c0 v0",
                  bus.sum, bus.cout, bus.overflow);
      end
   endtask

   task automatic test_held_start;
      int dones;
      int at;
      @(negedge clk);
      bus.a = 8'h01;
      bus.b = 8'h02;
      bus.cin = 1'b0;
      bus.start = 1'b1;
      dones = 0;
      at = -1;
      for (int i = 0; i <= 26; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            dones++;
            at = i;
         end
      end
      bus.start = 1'b0;
      n_chk++;
      if (dones !== 3 || at !== 26) begin
         n_fail++;
         $display("FAIL held_start: got %0d dones last %0d want 3 26",
                  dones, at);
      end
      n_chk++;
      if (bus.sum !== 8'h03) begin
         n_fail++;
         $display("FAIL held_sum: got %h want 03", bus.sum);
      end
      repeat (10) @(posedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      int lat;
      int bn;
      bus.sub = 1'b1;
      run_op(8'h10, 8'h20, 1'b0, lat, bn);
      bus.sub = 1'b0;
      n_chk++;
      if (lat !== 8 ||
          {bus.sum, bus.cout, bus.overflow} !== {8'hF0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL sub: got lat %0d %h c%b v%b want 8 f0 c0 v0",
                  lat, bus.sum, bus.cout, bus.overflow);
      end
   endtask
`endif

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      test_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      test_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      test_add(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_held_start();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
